riscv_perf_counters: RTL and testbench
======================================

# riscv_perf_counters

Parametrised performance-counter unit for the RI5CY core, successor to the fixed 11-counter PCCR/PCER/PCMR logic inside the CSR file. Provides N_CNT wide counters, each with its own event selector over N_EVENTS event lines, plus wrap/saturate mode, per-counter overflow status and a maskable overflow interrupt. It decodes its own CSR address window, and the CSR file muxes its read data in when `csr_hit_o` is high.

## Interface
- N_EVENTS, 16: number of event inputs (1..32).
- N_CNT, 4: number of counters (1..8).
- CNT_WIDTH, 48: counter width in bits (32..64).
- SEL_BITS, $clog2(N_EVENTS)+1: event-select field width; the extra bit allows "no event".
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- csr_access_i  in  1  CSR access qualifier.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  CSR write operand.
- csr_op_i  in  2  CSR_OP_NONE/WRITE/SET/CLEAR from riscv_defines.
- csr_rdata_o  out  32  read data for the addressed register, combinational.
- csr_hit_o  out  1  csr_access_i AND address inside the map.
- events_i  in  N_EVENTS  one-cycle event pulses or levels, counted per cycle high.
- irq_ovf_o  out  1  overflow interrupt, `|(ovf_q & ovf_ie_q)`, driven from registers only.

## Operation
- Address map (i = 0..N_CNT-1):
  - 0x780+i: counter low word [31:0].
  - 0x790+i: counter high word [CNT_WIDTH-1:32], zero-extended; reads 0 and ignores writes when CNT_WIDTH=32.
  - 0x7A0: enable mask [N_CNT-1:0].
  - 0x7A1: mode. Bit0 = global enable, bit1 = saturate (0 = wrap), bit2 = stop-on-overflow.
  - 0x7A2: overflow status [N_CNT-1:0].
  - 0x7A3: overflow IRQ enable [N_CNT-1:0].
  - 0x7A8+i: event select [SEL_BITS-1:0].
  - Unused bits read 0. Out-of-map addresses: csr_hit_o=0 and csr_rdata_o=0.
- Writes take effect when csr_hit_o=1 and op≠NONE:
  - WRITE: new = wdata.
  - SET: new = wdata | old.
  - CLEAR: new = ~wdata & old.
  - Results are truncated to the field width.
- Sampling stage: evt_q[i] <= events_i[sel_i] & en_q[i] & mode_q[0]. It is 0 when sel_i ≥ N_EVENTS.
- Increment stage: if evt_q[i], the counter increments by 1 across the full CNT_WIDTH. A carry from the low word into the high word occurs in the same cycle.
- Overflow condition: counter all-ones AND evt_q[i].
  - Wrap mode: counter goes to 0.
  - Saturate mode: counter holds all-ones.
  - In both modes ovf_q[i] is set. If mode bit2 is set, en_q[i] is cleared in the same edge.
  - A saturated counter that receives a further event sets ovf_q again; the bit is sticky either way.
- Priorities, evaluated per edge:
  - A CSR write to counter i's low or high word beats the increment. The pending increment is dropped and the unwritten word keeps its value.
  - Hardware ovf set beats a CSR clear of the same bit.
  - Stop-on-overflow enable clear beats a CSR write to the same enable bit.
- Reset values:
  - counters, en_q, ovf_q, ovf_ie_q, evt_q: 0.
  - sel_i: i mod N_EVENTS.
  - mode_q: 3'b001.
  - irq_ovf_o: 0.

## Timing
- An event high in cycle t is registered at the end of t. The counter updates at the end of t+1 and is readable in cycle t+2.
- Config writes made in cycle t first qualify sampling in cycle t+1.
- ovf_q and irq_ovf_o rise in the cycle after the overflowing increment edge, i.e. visible at t+2.
- A read in the same cycle as a write returns the old value. Read data is combinational, with zero latency.
- Sync reset asserted in any cycle clears evt_q, so no increment lands after reset deasserts.
- Counting is continuous: back-to-back events count once per cycle.

## Test plan
- Reset, then set enable=0x1, sel0=3, and pulse events_i[3] for 5 cycles. Expect 0x780 to read 5 two cycles after the last pulse; other counters stay 0.
- Wrap: write 0x790=0x0000FFFF and 0x780=0xFFFFFFFF, IRQ enable bit0, then one event. Expect counter=0, 0x7A2=0x1, irq_ovf_o=1. CLEAR 0x7A2 with 0x1 drops the irq the next cycle.
- Saturate with stop-on-overflow (mode=3'b111): preload all-ones, then 3 events. Expect the counter to hold 0xFFFF_FFFFFFFF, ovf bit set, and enable bit0 to read 0.
- Collision: in the same cycle evt_q[0]=1 and WRITE 0x780=0x100. Expect 0x100, not 0x101. Overflow set plus CSR clear of ovf in one cycle leaves the bit set.
- Global disable mode=0: events are ignored. Also sel=N_EVENTS never counts, and CSR SET/CLEAR on 0x7A0 gives the correct masks.
- Assert rst mid-count with event pipeline full. Expect all counters 0 and mode=3'b001, with no increment in the first post-reset cycle.

Source files
------------

// File: rtl/riscv_perf_counters.sv
// Parametrised performance-counter unit: N_CNT event-selectable counters with
// wrap/saturate modes, sticky overflow status and a maskable overflow interrupt.
module riscv_perf_counters #(
  parameter int unsigned N_EVENTS  = 16,
  parameter int unsigned N_CNT     = 4,
  parameter int unsigned CNT_WIDTH = 48,
  parameter int unsigned SEL_BITS  = $clog2(N_EVENTS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                csr_access_i,
  input  logic [11:0]         csr_addr_i,
  input  logic [31:0]         csr_wdata_i,
  input  logic [1:0]          csr_op_i,
  output logic [31:0]         csr_rdata_o,
  output logic                csr_hit_o,
  input  logic [N_EVENTS-1:0] events_i,
  output logic                irq_ovf_o
);

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam int unsigned EV_PAD = 1 << SEL_BITS;

  localparam logic [11:0] A_CNT_LO = 12'h780;
  localparam logic [11:0] A_CNT_HI = 12'h790;
  localparam logic [11:0] A_EN     = 12'h7A0;
  localparam logic [11:0] A_MODE   = 12'h7A1;
  localparam logic [11:0] A_OVF    = 12'h7A2;
  localparam logic [11:0] A_OVF_IE = 12'h7A3;
  localparam logic [11:0] A_SEL    = 12'h7A8;

  logic [CNT_WIDTH-1:0] r_cnt [N_CNT];
  logic [SEL_BITS-1:0]  r_sel [N_CNT];
  logic [N_CNT-1:0]     r_en;
  logic [N_CNT-1:0]     r_ovf;
  logic [N_CNT-1:0]     r_ovf_ie;
  logic [N_CNT-1:0]     r_evt;
  logic [2:0]           r_mode;

  logic [CNT_WIDTH-1:0] w_cnt_nxt [N_CNT];
  logic [SEL_BITS-1:0]  w_sel_nxt [N_CNT];
  logic [N_CNT-1:0]     w_en_nxt;
  logic [N_CNT-1:0]     w_ovf_nxt;
  logic [N_CNT-1:0]     w_ovf_ie_nxt;
  logic [N_CNT-1:0]     w_evt_nxt;
  logic [N_CNT-1:0]     w_ovf_hw;
  logic [2:0]           w_mode_nxt;
  logic [EV_PAD-1:0]    w_ev_pad;
  logic [63:0]          w_ext;
  logic [63:0]          w_rd_ext;
  logic [31:0]          w_rdata;
  logic                 w_in_map;
  logic                 w_wr;

  function automatic logic [31:0] f_apply(input logic [1:0]  op,
                                          input logic [31:0] wd,
                                          input logic [31:0] old);
    case (op)
      CSR_OP_WRITE: f_apply = wd;
      CSR_OP_SET:   f_apply = wd | old;
      CSR_OP_CLEAR: f_apply = ~wd & old;
      default:      f_apply = old;
    endcase
  endfunction

  // Address decode and combinational read mux
  always_comb begin
    w_in_map = 1'b0;
    w_rdata  = '0;
    w_rd_ext = '0;
    for (int i = 0; i < N_CNT; i++) begin
      if (csr_addr_i == A_CNT_LO + 12'(i)) begin
        w_in_map = 1'b1;
        w_rdata  = r_cnt[i][31:0];
      end
      if (csr_addr_i == A_CNT_HI + 12'(i)) begin
        w_in_map = 1'b1;
        w_rd_ext = 64'(r_cnt[i]);
        w_rdata  = w_rd_ext[63:32];
      end
      if (csr_addr_i == A_SEL + 12'(i)) begin
        w_in_map = 1'b1;
        w_rdata  = 32'(r_sel[i]);
      end
    end
    case (csr_addr_i)
      A_EN:     begin w_in_map = 1'b1; w_rdata = 32'(r_en);     end
      A_MODE:   begin w_in_map = 1'b1; w_rdata = 32'(r_mode);   end
      A_OVF:    begin w_in_map = 1'b1; w_rdata = 32'(r_ovf);    end
      A_OVF_IE: begin w_in_map = 1'b1; w_rdata = 32'(r_ovf_ie); end
      default:  ;
    endcase
  end

  assign csr_hit_o   = csr_access_i & w_in_map;
  assign csr_rdata_o = csr_hit_o ? w_rdata : 32'h0;
  assign irq_ovf_o   = |(r_ovf & r_ovf_ie);
  assign w_wr        = csr_hit_o & (csr_op_i != CSR_OP_NONE);
  assign w_ev_pad    = EV_PAD'(events_i);

  // Next state: CSR writes, event sampling, increment and overflow handling
  always_comb begin
    w_en_nxt     = r_en;
    w_ovf_nxt    = r_ovf;
    w_ovf_ie_nxt = r_ovf_ie;
    w_mode_nxt   = r_mode;
    w_ovf_hw     = '0;
    w_evt_nxt    = '0;
    w_ext        = '0;
    for (int i = 0; i < N_CNT; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_sel_nxt[i] = r_sel[i];
    end

    if (w_wr) begin
      case (csr_addr_i)
        A_EN:     w_en_nxt     = N_CNT'(f_apply(csr_op_i, csr_wdata_i, 32'(r_en)));
        A_MODE:   w_mode_nxt   = 3'(f_apply(csr_op_i, csr_wdata_i, 32'(r_mode)));
        A_OVF:    w_ovf_nxt    = N_CNT'(f_apply(csr_op_i, csr_wdata_i, 32'(r_ovf)));
        A_OVF_IE: w_ovf_ie_nxt = N_CNT'(f_apply(csr_op_i, csr_wdata_i, 32'(r_ovf_ie)));
        default:  ;
      endcase
    end

    for (int i = 0; i < N_CNT; i++) begin
      w_ext = 64'(r_cnt[i]);
      // A CSR write to either word drops the pending increment
      if (w_wr && csr_addr_i == A_CNT_LO + 12'(i)) begin
        w_ext[31:0]  = f_apply(csr_op_i, csr_wdata_i, w_ext[31:0]);
        w_cnt_nxt[i] = CNT_WIDTH'(w_ext);
      end else if (w_wr && csr_addr_i == A_CNT_HI + 12'(i)) begin
        w_ext[63:32] = f_apply(csr_op_i, csr_wdata_i, w_ext[63:32]);
        w_cnt_nxt[i] = CNT_WIDTH'(w_ext);
      end else if (r_evt[i]) begin
        if (&r_cnt[i]) begin
          w_ovf_hw[i]  = 1'b1;
          w_cnt_nxt[i] = r_mode[1] ? r_cnt[i] : '0;
        end else begin
          w_cnt_nxt[i] = r_cnt[i] + CNT_WIDTH'(1);
        end
      end
      if (w_wr && csr_addr_i == A_SEL + 12'(i)) begin
        w_sel_nxt[i] = SEL_BITS'(f_apply(csr_op_i, csr_wdata_i, 32'(r_sel[i])));
      end
      // Selects beyond N_EVENTS land on the zero padding
      w_evt_nxt[i] = w_ev_pad[r_sel[i]] & r_en[i] & r_mode[0];
    end

    w_ovf_nxt = w_ovf_nxt | w_ovf_hw;
    if (r_mode[2]) begin
      w_en_nxt = w_en_nxt & ~w_ovf_hw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CNT; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= SEL_BITS'(i % N_EVENTS);
      end
      r_en     <= '0;
      r_ovf    <= '0;
      r_ovf_ie <= '0;
      r_evt    <= '0;
      r_mode   <= 3'b001;
    end else begin
      for (int i = 0; i < N_CNT; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_sel[i] <= w_sel_nxt[i];
      end
      r_en     <= w_en_nxt;
      r_ovf    <= w_ovf_nxt;
      r_ovf_ie <= w_ovf_ie_nxt;
      r_evt    <= w_evt_nxt;
      r_mode   <= w_mode_nxt;
    end
  end

endmodule

// File: tb/tb_riscv_perf_counters.sv
// Directed scoreboard bench for riscv_perf_counters: stimulus queues expected
// read/irq values, a negedge monitor pops and compares them.
module tb_riscv_perf_counters;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_access;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic [31:0] csr_rdata;
  logic        csr_hit;
  logic [15:0] events;
  logic        irq_ovf;

  typedef struct {
    string       name;
    logic [32:0] exp;
    logic        is_irq;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [32:0] mon_got;
  logic        chk_req = 1'b0;
  int          n_vec   = 0;
  int          n_miss  = 0;

  riscv_perf_counters dut (
    .clk          (clk),
    .rst          (rst),
    .csr_access_i (csr_access),
    .csr_addr_i   (csr_addr),
    .csr_wdata_i  (csr_wdata),
    .csr_op_i     (csr_op),
    .csr_rdata_o  (csr_rdata),
    .csr_hit_o    (csr_hit),
    .events_i     (events),
    .irq_ovf_o    (irq_ovf)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (chk_req) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_miss++;
        $display("FAIL scoreboard_empty: check requested with no expectation queued");
      end else begin
        mon_e   = sb_q.pop_front();
        mon_got = mon_e.is_irq ? {32'h0, irq_ovf} : {csr_hit, csr_rdata};
        if (mon_got !== mon_e.exp) begin
          n_miss++;
          $display("FAIL %s: got %h, expected %h", mon_e.name, mon_got, mon_e.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_access = 1'b1;
    csr_addr   = a;
    csr_op     = op;
    csr_wdata  = d;
    tick();
    csr_access = 1'b0;
    csr_op     = OP_NONE;
    csr_wdata  = '0;
  endtask

  task automatic chk_rd(input string nm, input logic [11:0] a, input logic [31:0] v);
    exp_t e;
    e.name = nm; e.exp = {1'b1, v}; e.is_irq = 1'b0;
    sb_q.push_back(e);
    csr_access = 1'b1;
    csr_addr   = a;
    csr_op     = OP_NONE;
    chk_req    = 1'b1;
    tick();
    chk_req    = 1'b0;
    csr_access = 1'b0;
  endtask

  task automatic chk_miss(input string nm, input logic [11:0] a);
    exp_t e;
    e.name = nm; e.exp = 33'h0; e.is_irq = 1'b0;
    sb_q.push_back(e);
    csr_access = 1'b1;
    csr_addr   = a;
    csr_op     = OP_NONE;
    chk_req    = 1'b1;
    tick();
    chk_req    = 1'b0;
    csr_access = 1'b0;
  endtask

  task automatic chk_irq(input string nm, input logic v);
    exp_t e;
    e.name = nm; e.exp = {32'h0, v}; e.is_irq = 1'b1;
    sb_q.push_back(e);
    chk_req = 1'b1;
    tick();
    chk_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; csr_access = 1'b0; csr_addr = '0; csr_wdata = '0;
    csr_op = OP_NONE; events = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk_rd("rst_cnt0", 12'h780, 32'h0);
    chk_rd("rst_mode", 12'h7A1, 32'h1);
    chk_rd("rst_en", 12'h7A0, 32'h0);
    chk_rd("rst_sel1", 12'h7A9, 32'h1);
    chk_rd("rst_sel3", 12'h7AB, 32'h3);
    chk_rd("rst_ovf", 12'h7A2, 32'h0);
    chk_irq("rst_irq", 1'b0);
    chk_miss("out_of_map", 12'h7B0);

    // Basic counting: 5 pulses on event 3
    csr_wr(12'h7A0, OP_WRITE, 32'h1);
    csr_wr(12'h7A8, OP_WRITE, 32'h3);
    events[3] = 1'b1;
    repeat (5) tick();
    events = '0;
    chk_rd("count_t1", 12'h780, 32'h4);
    chk_rd("count_t2", 12'h780, 32'h5);
    chk_rd("count_hi", 12'h790, 32'h0);
    chk_rd("count_other", 12'h781, 32'h0);

    // Wrap with carry and overflow IRQ
    csr_wr(12'h790, OP_WRITE, 32'h0000FFFF);
    csr_wr(12'h780, OP_WRITE, 32'hFFFFFFFF);
    csr_wr(12'h7A3, OP_WRITE, 32'h1);
    events[3] = 1'b1;
    tick();
    events = '0;
    chk_rd("wrap_pre", 12'h780, 32'hFFFFFFFF);
    chk_irq("wrap_irq", 1'b1);
    chk_rd("wrap_lo", 12'h780, 32'h0);
    chk_rd("wrap_hi", 12'h790, 32'h0);
    chk_rd("wrap_ovf", 12'h7A2, 32'h1);
    csr_wr(12'h7A2, OP_CLEAR, 32'h1);
    chk_irq("irq_cleared", 1'b0);

    // Collision: write beats pending increment
    events[3] = 1'b1;
    tick();
    events = '0;
    csr_wr(12'h780, OP_WRITE, 32'h100);
    chk_rd("coll_wr_lo", 12'h780, 32'h100);
    chk_rd("coll_wr_hi", 12'h790, 32'h0);

    // Collision: hardware overflow set beats CSR clear
    csr_wr(12'h790, OP_WRITE, 32'h0000FFFF);
    csr_wr(12'h780, OP_WRITE, 32'hFFFFFFFF);
    events[3] = 1'b1;
    tick();
    events = '0;
    csr_wr(12'h7A2, OP_CLEAR, 32'h1);
    chk_rd("coll_ovf", 12'h7A2, 32'h1);
    chk_rd("coll_ovf_cnt", 12'h780, 32'h0);
    csr_wr(12'h7A2, OP_WRITE, 32'h0);

    // Saturate with stop-on-overflow
    csr_wr(12'h7A1, OP_WRITE, 32'h7);
    csr_wr(12'h790, OP_WRITE, 32'h0000FFFF);
    csr_wr(12'h780, OP_WRITE, 32'hFFFFFFFF);
    events[3] = 1'b1;
    repeat (3) tick();
    events = '0;
    repeat (2) tick();
    chk_rd("sat_lo", 12'h780, 32'hFFFFFFFF);
    chk_rd("sat_hi", 12'h790, 32'h0000FFFF);
    chk_rd("sat_ovf", 12'h7A2, 32'h1);
    chk_rd("sat_en_cleared", 12'h7A0, 32'h0);
    chk_irq("sat_irq", 1'b1);

    // Global disable ignores events
    csr_wr(12'h7A1, OP_WRITE, 32'h0);
    csr_wr(12'h7A2, OP_WRITE, 32'h0);
    csr_wr(12'h780, OP_WRITE, 32'h0);
    csr_wr(12'h790, OP_WRITE, 32'h0);
    csr_wr(12'h7A0, OP_WRITE, 32'h1);
    events[3] = 1'b1;
    repeat (4) tick();
    events = '0;
    repeat (2) tick();
    chk_rd("gdis_cnt0", 12'h780, 32'h0);

    // sel = N_EVENTS never counts; counter 3 on its reset select does
    csr_wr(12'h7A1, OP_WRITE, 32'h1);
    csr_wr(12'h7A8, OP_WRITE, 32'h10);
    csr_wr(12'h7A0, OP_WRITE, 32'h9);
    events = 16'hFFFF;
    repeat (3) tick();
    events = '0;
    repeat (2) tick();
    chk_rd("sel_none_cnt0", 12'h780, 32'h0);
    chk_rd("sel3_cnt3", 12'h783, 32'h3);
    chk_rd("sel0_readback", 12'h7A8, 32'h10);

    // Enable mask SET/CLEAR with truncation
    csr_wr(12'h7A0, OP_SET, 32'h6);
    chk_rd("en_set", 12'h7A0, 32'hF);
    csr_wr(12'h7A0, OP_CLEAR, 32'h5);
    chk_rd("en_clear", 12'h7A0, 32'hA);
    csr_wr(12'h7A0, OP_SET, 32'hFFFFFFF0);
    chk_rd("en_trunc", 12'h7A0, 32'hA);

    // Reset mid-count with the event pipeline full
    csr_wr(12'h7A2, OP_WRITE, 32'h3);
    events = 16'hFFFF;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    events = '0;
    chk_rd("mid_rst_cnt1", 12'h781, 32'h0);
    chk_rd("mid_rst_cnt3", 12'h783, 32'h0);
    chk_rd("mid_rst_mode", 12'h7A1, 32'h1);
    chk_rd("mid_rst_ovf", 12'h7A2, 32'h0);
    chk_irq("mid_rst_irq", 1'b0);

    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
